// File: rtl/chocorrol_pkg.sv
// Shared types for the Chocorrol datapath: instruction word layout,
// the bubble constant and the program sequencer state encoding.
package chocorrol_pkg;

  localparam int ANCHO_INSTR = 20;

  // Field layout, MSB first: WE_A 19, WE_B 18, DL1 17:13, SEL 12:10, DL2 9:5, DIR 4:0.
  typedef struct packed {
    logic       we_a;
    logic       we_b;
    logic [4:0] dl1;
    logic [2:0] sel;
    logic [4:0] dl2;
    logic [4:0] dir;
  } instruccion_t;

  // Both write enables low: the datapath treats this word as a no-op.
  localparam instruccion_t BURBUJA = 20'h00000;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CORRIENDO = 2'd1,
    FIN       = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_programa_contador.sv
// Program counter plus remaining-read and remaining-issue counters.
// Clear has priority over load; the two decrements are independent.
module contador_programa #(
  parameter int ANCHO_PC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                carga,
  input  logic                dec_lee,
  input  logic                dec_emite,
  input  logic                borrar,
  input  logic [ANCHO_PC-1:0] base,
  input  logic [ANCHO_PC-1:0] cuenta,
  output logic [ANCHO_PC-1:0] pc,
  output logic                lecturas_cero,
  output logic                emisiones_cero
);

  logic [ANCHO_PC-1:0] lecturas;
  logic [ANCHO_PC-1:0] emisiones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      lecturas  <= '0;
      emisiones <= '0;
    end else if (borrar) begin
      pc        <= '0;
      lecturas  <= '0;
      emisiones <= '0;
    end else if (carga) begin
      pc        <= base;
      lecturas  <= cuenta;
      emisiones <= cuenta;
    end else begin
      // PC wraps naturally from all-ones to zero.
      if (dec_lee) begin
        pc       <= pc + 1'b1;
        lecturas <= lecturas - 1'b1;
      end
      if (dec_emite) begin
        emisiones <= emisiones - 1'b1;
      end
    end
  end

  assign lecturas_cero  = (lecturas == '0);
  assign emisiones_cero = (emisiones == '0);

endmodule

// File: rtl/secuenciador_programa.sv
// Program sequencer: fetches a block of instructions from a synchronous ROM
// and issues one per cycle, driving bubbles whenever nothing is issued.
module secuenciador_programa
  import chocorrol_pkg::*;
#(
  parameter int ANCHO_PC = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   INICIO,
  input  logic [ANCHO_PC-1:0]    DIR_BASE,
  input  logic [ANCHO_PC-1:0]    CUENTA,
  input  logic                   PAUSA,
  input  logic                   ABORTAR,
  output logic [ANCHO_PC-1:0]    ROM_DIR,
  output logic                   ROM_LEE,
  input  logic [ANCHO_INSTR-1:0] ROM_DATO,
  output logic [ANCHO_INSTR-1:0] INSTRUCCION,
  output logic                   EMITIDA,
  output logic                   OCUPADO,
  output logic                   TERMINADO,
  output estado_t                ESTADO
);

  // ROM protocol: a read strobed in cycle t returns its word in t+1, which is
  // registered and shown on INSTRUCCION with EMITIDA=1 in t+2. There is no
  // back-pressure from the datapath; PAUSA only withholds new reads.

  logic [1:0]          rst_sinc;
  logic                rst_n_int;
  estado_t             estado;
  instruccion_t        instr_q;
  logic                emitida_q;
  logic                ocupado_q;
  logic                terminado_q;
  logic                dato_pendiente;
  logic                arranque;
  logic                emite;
  logic                borrar;
  logic [ANCHO_PC-1:0] pc;
  logic                lecturas_cero;
  logic                emisiones_cero;

  // Assertion is immediate; release waits two clock edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sinc <= 2'b00;
    else        rst_sinc <= {rst_sinc[0], 1'b1};
  end
  assign rst_n_int = rst_sinc[1];

  assign arranque = (estado == REPOSO) && INICIO && !ABORTAR;
  assign ROM_LEE  = (estado == CORRIENDO) && !lecturas_cero && !PAUSA && !ABORTAR;
  assign ROM_DIR  = (estado == CORRIENDO) ? pc : '0;
  assign emite    = (estado == CORRIENDO) && dato_pendiente && !ABORTAR;
  assign borrar   = ABORTAR || (estado == FIN);

  contador_programa #(
    .ANCHO_PC(ANCHO_PC)
  ) u_contador (
    .clk           (CLK),
    .rst_n         (rst_n_int),
    .carga         (arranque),
    .dec_lee       (ROM_LEE),
    .dec_emite     (emite),
    .borrar        (borrar),
    .base          (DIR_BASE),
    .cuenta        (CUENTA),
    .pc            (pc),
    .lecturas_cero (lecturas_cero),
    .emisiones_cero(emisiones_cero)
  );

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      estado         <= REPOSO;
      instr_q        <= BURBUJA;
      emitida_q      <= 1'b0;
      ocupado_q      <= 1'b0;
      terminado_q    <= 1'b0;
      dato_pendiente <= 1'b0;
    end else begin
      dato_pendiente <= ROM_LEE;
      instr_q        <= emite ? instruccion_t'(ROM_DATO) : BURBUJA;
      emitida_q      <= emite;
      terminado_q    <= 1'b0;
      if (ABORTAR) begin
        // The in-flight word is dropped through emite and the counter clear.
        estado    <= REPOSO;
        ocupado_q <= 1'b0;
      end else begin
        case (estado)
          REPOSO: begin
            if (arranque) begin
              if (CUENTA != '0) begin
                estado    <= CORRIENDO;
                ocupado_q <= 1'b1;
              end else begin
                estado      <= FIN;
                terminado_q <= 1'b1;
              end
            end
          end
          CORRIENDO: begin
            // Issue count reaches zero during the cycle showing the last issue.
            if (emisiones_cero) begin
              estado      <= FIN;
              ocupado_q   <= 1'b0;
              terminado_q <= 1'b1;
            end
          end
          FIN: begin
            estado <= REPOSO;
          end
          default: begin
            estado    <= REPOSO;
            ocupado_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign INSTRUCCION = instr_q;
  assign EMITIDA     = emitida_q;
  assign OCUPADO     = ocupado_q;
  assign TERMINADO   = terminado_q;
  assign ESTADO      = estado;

endmodule

// File: tb/tb_secuenciador_programa.sv
// Directed bench for secuenciador_programa: a schedule-level model derived
// from the timing rules, checked every cycle, plus literal pins per scenario.
module tb_secuenciador_programa;
  import chocorrol_pkg::*;

  localparam int LEN = 16;

  logic        CLK;
  logic        RST_N;
  logic        INICIO;
  logic [7:0]  DIR_BASE;
  logic [7:0]  CUENTA;
  logic        PAUSA;
  logic        ABORTAR;
  logic [7:0]  ROM_DIR;
  logic        ROM_LEE;
  logic [19:0] ROM_DATO;
  logic [19:0] INSTRUCCION;
  logic        EMITIDA;
  logic        OCUPADO;
  logic        TERMINADO;
  estado_t     ESTADO;

  secuenciador_programa #(.ANCHO_PC(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .INICIO     (INICIO),
    .DIR_BASE   (DIR_BASE),
    .CUENTA     (CUENTA),
    .PAUSA      (PAUSA),
    .ABORTAR    (ABORTAR),
    .ROM_DIR    (ROM_DIR),
    .ROM_LEE    (ROM_LEE),
    .ROM_DATO   (ROM_DATO),
    .INSTRUCCION(INSTRUCCION),
    .EMITIDA    (EMITIDA),
    .OCUPADO    (OCUPADO),
    .TERMINADO  (TERMINADO),
    .ESTADO     (ESTADO)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- program ROM model ----------------
  logic [19:0] rom [256];
  always @(posedge CLK) ROM_DATO <= ROM_LEE ? rom[ROM_DIR] : 20'($urandom);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic        exp_lee   [LEN];
  logic [7:0]  exp_dir   [LEN];
  logic        exp_emit  [LEN];
  logic [19:0] exp_instr [LEN];
  logic        exp_ocup  [LEN];
  logic        exp_term  [LEN];

  logic        got_emit  [LEN];
  logic [7:0]  got_dir   [LEN];
  logic [19:0] got_instr [LEN];
  logic        got_term  [LEN];

  logic chk_en  = 1'b0;
  int   chk_cyc = 0;

  task automatic comprobar(input string nombre, input int c, input logic [31:0] got,
                           input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc %0d got %h want %h", nombre, c, got, want);
    end
  endtask

  // Schedule model: INICIO in cycle 0; reads in the first unpaused cycles
  // from 1 on; each read shows up two cycles later unless an abort comes
  // first; TERMINADO one cycle after the last issue.
  task automatic construir(input logic [7:0] base, input int n, input logic [LEN-1:0] pausa,
                           input int aborto);
    logic [7:0] dir;
    int quedan;
    int ultima;
    int fin_ocup;
    for (int c = 0; c < LEN; c++) begin
      exp_lee[c] = 1'b0; exp_dir[c] = 8'h00; exp_emit[c] = 1'b0;
      exp_instr[c] = 20'h00000; exp_ocup[c] = 1'b0; exp_term[c] = 1'b0;
    end
    if (aborto == 0) return;
    if (n == 0) begin
      exp_term[1] = 1'b1;
      return;
    end
    dir = base; quedan = n; ultima = 0;
    for (int c = 1; c < LEN && quedan > 0; c++) begin
      if (aborto > 0 && c >= aborto) break;
      if (!pausa[c]) begin
        exp_lee[c] = 1'b1;
        exp_dir[c] = dir;
        if ((aborto < 0 || c + 2 <= aborto) && c + 2 < LEN) begin
          exp_emit[c+2]  = 1'b1;
          exp_instr[c+2] = rom[dir];
          ultima = c + 2;
        end
        dir = dir + 8'd1;
        quedan--;
      end
    end
    fin_ocup = (aborto > 0) ? aborto : ultima;
    for (int c = 1; c <= fin_ocup && c < LEN; c++) exp_ocup[c] = 1'b1;
    if (aborto < 0 && ultima + 1 < LEN) exp_term[ultima+1] = 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      int c;
      estado_t want_est;
      c = chk_cyc;
      got_emit[c] = EMITIDA; got_dir[c] = ROM_DIR;
      got_instr[c] = INSTRUCCION; got_term[c] = TERMINADO;
      want_est = exp_ocup[c] ? CORRIENDO : (exp_term[c] ? FIN : REPOSO);
      comprobar("rom_lee", c, 32'(ROM_LEE), 32'(exp_lee[c]));
      if (exp_lee[c]) comprobar("rom_dir", c, 32'(ROM_DIR), 32'(exp_dir[c]));
      comprobar("emitida", c, 32'(EMITIDA), 32'(exp_emit[c]));
      comprobar("instruccion", c, 32'(INSTRUCCION), 32'(exp_instr[c]));
      comprobar("ocupado", c, 32'(OCUPADO), 32'(exp_ocup[c]));
      comprobar("terminado", c, 32'(TERMINADO), 32'(exp_term[c]));
      comprobar("estado", c, 32'(ESTADO), 32'(want_est));
    end
  end

  // ---------------- driver ----------------
  task automatic run_test(input logic [7:0] base, input logic [7:0] n,
                          input logic [LEN-1:0] pausa, input int aborto, input int extra);
    construir(base, int'(n), pausa, aborto);
    for (int c = 0; c < LEN; c++) begin
      INICIO = (c == 0) || (c == extra);
      if (c == 0) begin
        DIR_BASE = base; CUENTA = n;
      end else if (c == extra) begin
        DIR_BASE = 8'h90; CUENTA = 8'd7;
      end else begin
        DIR_BASE = 8'($urandom); CUENTA = 8'($urandom);
      end
      PAUSA   = pausa[c];
      ABORTAR = (c == aborto);
      chk_cyc = c;
      chk_en  = 1'b1;
      @(posedge CLK); #1;
    end
    chk_en = 1'b0; INICIO = 1'b0; PAUSA = 1'b0; ABORTAR = 1'b0;
  endtask

  task automatic salidas_en_cero(input string nombre);
    comprobar({nombre, "_instr"}, 0, 32'(INSTRUCCION), 32'h0);
    comprobar({nombre, "_emit"}, 0, 32'(EMITIDA), 32'h0);
    comprobar({nombre, "_lee"}, 0, 32'(ROM_LEE), 32'h0);
    comprobar({nombre, "_dir"}, 0, 32'(ROM_DIR), 32'h0);
    comprobar({nombre, "_ocup"}, 0, 32'(OCUPADO), 32'h0);
    comprobar({nombre, "_term"}, 0, 32'(TERMINADO), 32'h0);
    comprobar({nombre, "_estado"}, 0, 32'(ESTADO), 32'(REPOSO));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 20'($urandom_range(20'hFFFFF, 1));
    rom[8'h10] = 20'hC2421; rom[8'h11] = 20'h40000; rom[8'h12] = 20'h80A5F;
    RST_N = 1'b0; INICIO = 1'b0; DIR_BASE = 8'h00; CUENTA = 8'h00;
    PAUSA = 1'b0; ABORTAR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 salidas_en_cero("reset");
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // 1: basic run
    run_test(8'h10, 8'd3, 16'h0000, -1, -1);
    comprobar("t1_dir_k1", 1, 32'(got_dir[1]), 32'h10);
    comprobar("t1_instr_k3", 3, 32'(got_instr[3]), 32'hC2421);
    comprobar("t1_instr_k4", 4, 32'(got_instr[4]), 32'h40000);
    comprobar("t1_instr_k5", 5, 32'(got_instr[5]), 32'h80A5F);
    comprobar("t1_term_k6", 6, 32'(got_term[6]), 32'h1);

    // 2: wrap-around
    run_test(8'hFE, 8'd4, 16'h0000, -1, -1);
    comprobar("t2_dir_k2", 2, 32'(got_dir[2]), 32'hFF);
    comprobar("t2_dir_k3", 3, 32'(got_dir[3]), 32'h00);
    comprobar("t2_dir_k4", 4, 32'(got_dir[4]), 32'h01);

    // 3: pause for two cycles after the second read
    run_test(8'h30, 8'd4, 16'h0018, -1, -1);
    comprobar("t3_emit_k5", 5, 32'(got_emit[5]), 32'h0);
    comprobar("t3_emit_k6", 6, 32'(got_emit[6]), 32'h0);
    comprobar("t3_emit_k7", 7, 32'(got_emit[7]), 32'h1);
    comprobar("t3_term_k9", 9, 32'(got_term[9]), 32'h1);

    // 4: empty program, then a start ignored while busy
    run_test(8'h33, 8'd0, 16'h0000, -1, -1);
    comprobar("t4_term_k1", 1, 32'(got_term[1]), 32'h1);
    run_test(8'h50, 8'd3, 16'h0000, -1, 2);
    comprobar("t4b_term_k6", 6, 32'(got_term[6]), 32'h1);

    // 5: abort after the second read; abort together with start
    run_test(8'h10, 8'd5, 16'h0000, 3, -1);
    comprobar("t5_instr_k3", 3, 32'(got_instr[3]), 32'hC2421);
    comprobar("t5_instr_k4", 4, 32'(got_instr[4]), 32'h0);
    comprobar("t5_term_k8", 8, 32'(got_term[8]), 32'h0);
    run_test(8'h10, 8'd3, 16'h0000, 0, -1);

    // 6: reset mid-program, then a fresh run
    INICIO = 1'b1; DIR_BASE = 8'h40; CUENTA = 8'd5;
    @(posedge CLK); #1;
    INICIO = 1'b0;
    repeat (3) @(posedge CLK);
    #1 comprobar("t6_emit_before", 4, 32'(EMITIDA), 32'h1);
    #2 RST_N = 1'b0;
    #1 salidas_en_cero("t6_async");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    run_test(8'h20, 8'd2, 16'h0000, -1, -1);
    comprobar("t6_dir_k1", 1, 32'(got_dir[1]), 32'h20);
    comprobar("t6_term_k5", 5, 32'(got_term[5]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secuenciador_programa.md
# secuenciador_programa

Program sequencer for the Chocorrol datapath. On a start command it fetches a block of 20-bit instructions from an external synchronous program ROM and issues them, one per cycle, on the datapath's `INSTRUCCION` bus. Between and after programs it drives bubbles with both write enables low, so the register file and data memory never see spurious writes. It supports pause, abort and a completion pulse.

## Interface
- `ANCHO_PC`, 8: width of the program address and the instruction count.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `INICIO` input 1: start strobe; sampled only in REPOSO.
- `DIR_BASE` input ANCHO_PC: first program address; latched on an accepted `INICIO`.
- `CUENTA` input ANCHO_PC: number of instructions to issue; latched on an accepted `INICIO`. Value 0 means empty program.
- `PAUSA` input 1: holds off new ROM reads while high.
- `ABORTAR` input 1: synchronous abort; has priority over everything except reset.
- `ROM_DIR` output ANCHO_PC: program ROM address.
- `ROM_LEE` output 1: ROM read strobe.
- `ROM_DATO` input 20: ROM data, valid in the cycle after `ROM_LEE`.
- `INSTRUCCION` output 20: registered instruction to the datapath.
- `EMITIDA` output 1: `INSTRUCCION` holds a real instruction this cycle.
- `OCUPADO` output 1: a program is running.
- `TERMINADO` output 1: one-cycle completion pulse.

## Operation
- States:
  - **REPOSO**: waits for `INICIO`.
    - `INICIO` with `CUENTA`≠0 → CORRIENDO. PC, read count and issue count are each set from the latched inputs (PC = `DIR_BASE`, both counts = `CUENTA`).
    - `INICIO` with `CUENTA`=0 → FIN. No ROM read occurs.
  - **CORRIENDO**:
    - `ROM_LEE` = (remaining reads > 0) and not `PAUSA` and not `ABORTAR`.
    - `ROM_DIR` = PC.
    - Each read increments PC and decrements the remaining-read count.
  - **FIN**: lasts one cycle with `TERMINADO`=1, then → REPOSO.
- Issue: a read in cycle t has `ROM_DATO` captured at the end of t+1. In t+2, `INSTRUCCION` equals that word bit-exact and `EMITIDA`=1. Each issue decrements the remaining-issue count.
- Bubble: in any cycle without an issue, `INSTRUCCION` = 20'h00000 and `EMITIDA`=0.
- `PAUSA` only blocks new reads. A read already in flight is still issued, even if `PAUSA` rises.
- When the last issue is visible in cycle t, the state is FIN in t+1.
- `OCUPADO` = 1 exactly in CORRIENDO.
- PC arithmetic is modulo 2^ANCHO_PC; the address wraps from all-ones to 0.
- `INICIO` outside REPOSO is ignored. The latched `DIR_BASE`/`CUENTA` are unaffected by later input changes.
- `ABORTAR` in CORRIENDO or FIN:
  - next state is REPOSO;
  - any in-flight read is discarded, so its word is never issued;
  - no `TERMINADO` pulse;
  - `INSTRUCCION` is a bubble from the next cycle.
- `ABORTAR` and `INICIO` in the same REPOSO cycle: abort wins, and the start is dropped.

## Timing
- Reset values: `INSTRUCCION`=0, `EMITIDA`=0, `ROM_LEE`=0, `ROM_DIR`=0, `OCUPADO`=0, `TERMINADO`=0, state REPOSO, all counters 0.
- Reset is asserted asynchronously; release is synchronised.
- Reset mid-program: outputs go to their reset values immediately. The program is lost.
- Without pause, `INICIO` sampled at edge k gives:
  - `ROM_LEE` in cycles k+1..k+N;
  - `EMITIDA` in cycles k+3..k+N+2;
  - `TERMINADO` in cycle k+N+3.
- Throughput is one instruction per cycle. Each pause cycle adds exactly one bubble.
- `ROM_DIR` and `ROM_LEE` are decoded from registered state. `PAUSA` and `ABORTAR` feed `ROM_LEE` combinationally.

## Structure
- Shared package `chocorrol_pkg` holds:
  - field positions of the instruction word: WE_A bit 19, WE_B bit 18, DL1 17:13, SEL 12:10, DL2 9:5, DIR 4:0;
  - the bubble constant 20'h00000;
  - the state enum {REPOSO, CORRIENDO, FIN}.
- One sub-module, `contador_programa`, holds PC and the remaining-read and remaining-issue counters. It has load, read-decrement, issue-decrement and clear inputs, and flag outputs for reads-zero and issues-zero.
- The FSM and the output register stay in `secuenciador_programa`.

## Test plan
1. **Basic run.** `DIR_BASE`=0x10, `CUENTA`=3; ROM[0x10..0x12]=0xC2421, 0x40000, 0x80A5F. Expect:
   - `ROM_DIR` 0x10, 0x11, 0x12 on consecutive cycles;
   - `INSTRUCCION` equal to those three words with `EMITIDA`=1 in k+3..k+5;
   - `TERMINADO` in k+6;
   - 0x00000 at all other times.
2. **Wrap-around.** `DIR_BASE`=0xFE, `CUENTA`=4. Expect `ROM_DIR` sequence 0xFE, 0xFF, 0x00, 0x01 and four issues in order.
3. **Pause.** `CUENTA`=4 with `PAUSA` high for 2 cycles after the second read. Expect:
   - exactly 2 bubbles between issues 2 and 3;
   - the in-flight word still issued;
   - `TERMINADO` 2 cycles later than the unpaused run.
4. **Empty program and ignored start.** `CUENTA`=0 → `TERMINADO` in k+1, no `ROM_LEE`, no `EMITIDA`. A second `INICIO` while `OCUPADO`=1 → no effect on count or addresses.
5. **Abort.** `ABORTAR` in the cycle after the second read of a 5-instruction program. Expect:
   - only word 1 issued;
   - word 2 dropped;
   - REPOSO next cycle, `OCUPADO`=0, no `TERMINADO`.
6. **Reset mid-program.** `RST_N` low asynchronously mid-program → all outputs 0 before the next clock edge. After release, a new `INICIO` runs normally from its own `DIR_BASE`.
